// File: rtl/keypad_pkg.sv
// Shared key-code constants, FSM state type and key classification helpers for the
// keypad entry buffer.
package keypad_pkg;

    localparam int unsigned KEY_W = 6;

    localparam logic [KEY_W-1:0] KEY_STAR = 6'd10;
    localparam logic [KEY_W-1:0] KEY_HASH = 6'd11;
    localparam logic [KEY_W-1:0] KEY_NONE = 6'h3F;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_RELEASE
    } entry_state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return k <= 6'd9;
    endfunction

    // Anything outside 0..11 is folded onto KEY_NONE.
    function automatic logic is_known_key(input logic [KEY_W-1:0] k);
        return (k <= KEY_HASH) || (k == KEY_NONE);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus stability counter; stable_key only follows a code that
// has stayed unchanged for DEBOUNCE_CYCLES clocks.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] num,
    output logic [KEY_W-1:0] stable_key
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync1_q, sync2_q, samp_q, norm;
    logic [CntW-1:0]  cnt_q;

    assign norm = is_known_key(sync2_q) ? sync2_q : KEY_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= KEY_NONE;
            sync2_q    <= KEY_NONE;
            samp_q     <= KEY_NONE;
            stable_key <= KEY_NONE;
            cnt_q      <= '0;
        end else begin
            sync1_q <= num;
            sync2_q <= sync1_q;
            samp_q  <= norm;
            if (norm != samp_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                stable_key <= samp_q;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad digit accumulator: one action per debounced keystroke, BCD and binary
// buffers, '*' clears and '#' delivers a one-cycle validated entry.
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned MAX_DIGITS      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] num,
    output logic [15:0]      digits_bcd,
    output logic [2:0]       digit_count,
    output logic [13:0]      value,
    output logic             entry_valid,
    output logic             entry_error,
    output logic             key_pulse
);

    localparam logic [15:0] BcdMask = 16'hFFFF >> (16 - 4 * MAX_DIGITS);

    logic [KEY_W-1:0] stable_key;
    entry_state_e     state_q, state_d;
    logic [15:0]      bcd_d;
    logic [13:0]      val_d;
    logic [2:0]       cnt_d;
    logic             valid_d, error_d, pulse_d, clr_q, clr_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .stable_key(stable_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            digits_bcd  <= '0;
            value       <= '0;
            digit_count <= '0;
            entry_valid <= 1'b0;
            entry_error <= 1'b0;
            key_pulse   <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_bcd  <= bcd_d;
            value       <= val_d;
            digit_count <= cnt_d;
            entry_valid <= valid_d;
            entry_error <= error_d;
            key_pulse   <= pulse_d;
            clr_q       <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = digits_bcd;
        val_d   = value;
        cnt_d   = digit_count;
        valid_d = 1'b0;
        error_d = 1'b0;
        pulse_d = 1'b0;
        clr_d   = 1'b0;

        // Entry was delivered last cycle; drop it now.
        if (clr_q) begin
            bcd_d = '0;
            val_d = '0;
            cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (stable_key != KEY_NONE) begin
                    pulse_d = 1'b1;
                    state_d = WAIT_RELEASE;
                    if (is_digit(stable_key)) begin
                        if (digit_count < 3'(MAX_DIGITS)) begin
                            bcd_d = {digits_bcd[11:0], stable_key[3:0]} & BcdMask;
                            val_d = (value << 3) + (value << 1) + {10'd0, stable_key[3:0]};
                            cnt_d = digit_count + 3'd1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (stable_key == KEY_STAR) begin
                        bcd_d = '0;
                        val_d = '0;
                        cnt_d = '0;
                    end else if (digit_count != 3'd0) begin
                        valid_d = 1'b1;
                        clr_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (stable_key == KEY_NONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench for keypad_entry_buffer: a reference model queues the expected
// result of each keystroke and a monitor compares it on every key_pulse.
module tb_keypad_entry_buffer;

    localparam int unsigned DEB = 8;

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] bcd;
        logic [13:0] val;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  num = 6'h3F;
    logic [15:0] digits_bcd;
    logic [2:0]  digit_count;
    logic [13:0] value;
    logic        entry_valid, entry_error, key_pulse;

    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    exp_t sb_q[$];

    logic [15:0] m_bcd = '0;
    logic [13:0] m_val = '0;
    logic [2:0]  m_cnt = '0;

    keypad_entry_buffer #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DIGITS     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .num        (num),
        .digits_bcd (digits_bcd),
        .digit_count(digit_count),
        .value      (value),
        .entry_valid(entry_valid),
        .entry_error(entry_error),
        .key_pulse  (key_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: update state and queue what the DUT should show on key_pulse.
    task automatic model_key(input logic [5:0] k);
        exp_t x;
        x.v = 1'b0;
        x.e = 1'b0;
        if (k <= 6'd9) begin
            if (m_cnt < 3'd4) begin
                m_bcd = {m_bcd[11:0], k[3:0]};
                m_val = m_val * 14'd10 + 14'(k);
                m_cnt = m_cnt + 3'd1;
            end else begin
                x.e = 1'b1;
            end
        end else if (k == 6'd10) begin
            m_bcd = '0;
            m_val = '0;
            m_cnt = '0;
        end else if (k == 6'd11) begin
            if (m_cnt == 3'd0) x.e = 1'b1;
            else x.v = 1'b1;
        end
        x.bcd = m_bcd;
        x.val = m_val;
        x.cnt = m_cnt;
        sb_q.push_back(x);
        if (x.v) begin
            m_bcd = '0;
            m_val = '0;
            m_cnt = '0;
        end
    endtask

    task automatic hold_key(input logic [5:0] k, input int cycles);
        num = k;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic press(input logic [5:0] k);
        model_key(k);
        hold_key(k, 20);
        hold_key(6'h3F, 20);
    endtask

    // Monitor: pops one expectation per key_pulse, and checks the post-'#' clear.
    always @(negedge clk) begin : monitor
        static logic clr_due = 1'b0;
        exp_t x;
        if (clr_due) begin
            check_eq("clear_after_valid", {digits_bcd, value, 5'd0, digit_count},
                     {16'h0, 14'h0, 5'd0, 3'd0});
            clr_due = 1'b0;
        end
        if (!rst && (entry_valid || entry_error) && !key_pulse)
            check_eq("stray_flag", 32'd1, 32'd0);
        if (!rst && key_pulse) begin
            pulses++;
            if (sb_q.size() == 0) begin
                check_eq("extra_key_pulse", 32'd1, 32'd0);
            end else begin
                x = sb_q.pop_front();
                check_eq("entry_valid", 32'(entry_valid), 32'(x.v));
                check_eq("entry_error", 32'(entry_error), 32'(x.e));
                check_eq("digits_bcd", 32'(digits_bcd), 32'(x.bcd));
                check_eq("value", 32'(value), 32'(x.val));
                check_eq("digit_count", 32'(digit_count), 32'(x.cnt));
                if (x.v) clr_due = 1'b1;
            end
        end
    end

    initial begin : stim
        int p0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {digits_bcd, value, digit_count, entry_valid, entry_error,
                 key_pulse}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1,2,5,# -> 0x0125 / 125
        press(6'd1);
        press(6'd2);
        press(6'd5);
        press(6'd11);

        // 9 interrupted by short 3F glitches is one keystroke
        model_key(6'd9);
        hold_key(6'd9, 20);
        hold_key(6'h3F, 3);
        hold_key(6'd9, 20);
        hold_key(6'h3F, 3);
        hold_key(6'd9, 20);
        hold_key(6'h3F, 20);
        check_eq("glitch_count", 32'(digit_count), 32'd1);

        // Overflow on fifth digit
        press(6'd10);
        press(6'd1);
        press(6'd2);
        press(6'd3);
        press(6'd4);
        press(6'd5);

        // Clear, then '#' on empty buffer is an error; unknown code is ignored
        press(6'd10);
        press(6'd7);
        press(6'd7);
        press(6'd10);
        press(6'd11);
        hold_key(6'h20, 30);
        hold_key(6'h3F, 20);

        // Long hold and direct 8->3 change give one pulse only
        p0 = pulses;
        model_key(6'd8);
        hold_key(6'd8, 1000);
        hold_key(6'd3, 30);
        hold_key(6'h3F, 20);
        check_eq("hold_pulses", 32'(pulses - p0), 32'd1);
        check_eq("hold_count", 32'(digit_count), 32'd1);

        // Reset while 4 is held, then it is accepted again after debounce
        press(6'd1);
        model_key(6'd4);
        hold_key(6'd4, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_reset", {digits_bcd, value, digit_count, entry_valid, entry_error,
                 key_pulse}, 32'd0);
        m_bcd = '0;
        m_val = '0;
        m_cnt = '0;
        p0 = pulses;
        model_key(6'd4);
        repeat (DEB) @(negedge clk);
        check_eq("no_early_accept", 32'(pulses - p0), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("reaccept_pulses", 32'(pulses - p0), 32'd1);
        check_eq("reaccept_count", 32'(digit_count), 32'd1);
        hold_key(6'h3F, 20);

        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_buffer.md
Name: keypad_entry_buffer

Overview:
- Sits directly downstream of the matrix-keypad scanner and consumes its 6-bit key code.
- Synchronises and debounces the key code, then detects one press per physical keystroke.
- Accumulates up to MAX_DIGITS decimal digits into BCD and binary form, with '*' as clear and '#' as enter.
- Delivers a one-cycle validated entry, for example a disinfection time in seconds, to the chamber controller and the display mux.

Parameters:
- DEBOUNCE_CYCLES, 50000: clk cycles the synchronised key code must stay unchanged before it is accepted (1 ms at 50 MHz).
- MAX_DIGITS, 4: maximum number of digits held. The range is 1..4 and sets the BCD and binary widths.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- num  in  6  key code from the scanner, asynchronous to this block's logic, so it is synchronised internally.
- digits_bcd  out  16  entered digits as BCD, newest digit in [3:0], unused nibbles 0.
- digit_count  out  3  number of digits currently held, 0..MAX_DIGITS.
- value  out  14  binary equivalent of digits_bcd.
- entry_valid  out  1  one-cycle pulse on accepted '#'.
- entry_error  out  1  one-cycle pulse when '#' is pressed with digit_count==0, or a digit is pressed while full.
- key_pulse  out  1  one-cycle pulse for every accepted keystroke, used for buzzer or UI feedback.

Behaviour:
- Key codes (package constants):
  - 0..9 are digits.
  - 10 is KEY_STAR.
  - 11 is KEY_HASH.
  - 6'h3F is KEY_NONE.
  - Any other code is treated as KEY_NONE.
- Input path:
  - num passes through a 2-flop synchroniser.
  - A debounce counter reloads whenever the synchronised code differs from the previous sample.
  - When the counter reaches DEBOUNCE_CYCLES-1, the code is copied to stable_key.
- FSM states:
  - IDLE: waits for stable_key != KEY_NONE. It then processes the key in that same cycle (actions below), pulses key_pulse and moves to WAIT_RELEASE.
  - WAIT_RELEASE: stays here until stable_key == KEY_NONE, then returns to IDLE. This gives exactly one action per press; auto-repeat is ignored.
  - Processing takes one cycle, so all output updates and pulses appear on the clock edge after stable_key changes.
- Key actions:
  - Digit d with digit_count < MAX_DIGITS:
    - digits_bcd <= {digits_bcd[11:0], d}, masked to MAX_DIGITS nibbles.
    - value <= value*10 + d.
    - digit_count increments.
  - Digit with digit_count == MAX_DIGITS: state is unchanged and entry_error pulses.
  - KEY_STAR: digits_bcd, value and digit_count clear to 0. No error, even if already empty.
  - KEY_HASH with digit_count > 0:
    - entry_valid pulses.
    - digits_bcd and value hold the entered number during the pulse cycle.
    - On the next cycle the buffer clears to 0.
  - KEY_HASH with digit_count == 0: entry_error pulses and nothing changes.
- Arithmetic:
  - value*10 is computed as (value<<3)+(value<<1) in 14 bits; no overflow is possible at MAX_DIGITS=4.
  - Leading zeros count as digits, so "0","0","7" gives count 3 and value 7.
- Reset:
  - Synchronous; overrides everything.
  - All outputs go to 0, the FSM returns to IDLE, the synchroniser and stable_key are set to KEY_NONE, and the debounce counter is zeroed.
  - A key held through reset deassertion is accepted once, after the full debounce time.
- Glitches shorter than DEBOUNCE_CYCLES never reach stable_key.
- A direct change from one key to another without passing through KEY_NONE is not a new press; only release re-arms the FSM.

Decomposition:
- Shared package keypad_pkg holds:
  - KEY_STAR, KEY_HASH and KEY_NONE constants.
  - The key-code width (6).
  - The FSM state enum {IDLE, WAIT_RELEASE}.
- One sub-module, key_debouncer (synchroniser plus stability counter, output stable_key), is natural; the FSM and accumulator stay in the top level.

Test Plan (DEBOUNCE_CYCLES=8 to keep simulation short):
- Press 1, 2, 5, then '#', releasing each key: entry_valid pulses once with digits_bcd=16'h0125 and value=125. The next cycle shows count 0 and value 0.
- Press 9 with 3-cycle glitches of 3F between presses: no key_pulse for the glitches, and exactly one digit 9 is accepted.
- Press 1, 2, 3, 4, 5: the buffer holds 16'h1234 (value 1234, count 4) and entry_error pulses on the 5.
- Press 7, 7, '*', '#': after '*' the count is 0, and '#' gives entry_error with no entry_valid.
- Hold 8 for 1000 cycles: exactly one key_pulse and count 1. Changing 8→3 directly without release produces no new key_pulse.
- Assert rst for 1 cycle mid-entry while 4 is held: all outputs are 0. After deassertion, 4 is accepted after 8 stable cycles and count becomes 1.
